// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit pipelined CPU: widths, opcodes,
// fetch FSM states and the IF/ID bubble encoding.
package cpu_pkg;

   localparam int PC_W = 16;

   // Opcodes (instr[15:12]) that the front end cares about
   localparam logic [3:0] OP_B   = 4'hC;   // conditional branch
   localparam logic [3:0] OP_BR  = 4'hD;   // branch to register
   localparam logic [3:0] OP_PCS = 4'hE;   // PC save (link = PC+2)
   localparam logic [3:0] HLT_OP = 4'hF;   // halt

   // Fetch sequencer states
   typedef enum logic [1:0] {
      ST_FETCH      = 2'd0,
      ST_REDIR_PEND = 2'd1,
      ST_HALTED     = 2'd2
   } fetch_state_t;

   // An empty IF/ID slot carries all-zero payload
   localparam logic [PC_W-1:0] BUBBLE_INSTR    = '0;
   localparam logic [PC_W-1:0] BUBBLE_PC_PLUS2 = '0;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. flush inserts a bubble, hold keeps the
// current contents, otherwise the incoming fetch result is captured.
module if_id_reg
   import cpu_pkg::*;
#(
   parameter int W = cpu_pkg::PC_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         hold,
   input  logic [W-1:0] instr_in,
   input  logic [W-1:0] pc_plus2_in,
   output logic [W-1:0] instr,
   output logic [W-1:0] pc_plus2,
   output logic         valid
);

   logic [W-1:0] instr_reg;
   logic [W-1:0] pc_plus2_reg;
   logic         valid_reg;

   // Register update: flush beats hold, hold beats load
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr_reg    <= BUBBLE_INSTR;
         pc_plus2_reg <= BUBBLE_PC_PLUS2;
         valid_reg    <= 1'b0;
      end else if (flush) begin
         instr_reg    <= BUBBLE_INSTR;
         pc_plus2_reg <= BUBBLE_PC_PLUS2;
         valid_reg    <= 1'b0;
      end else if (!hold) begin
         instr_reg    <= instr_in;
         pc_plus2_reg <= pc_plus2_in;
         valid_reg    <= 1'b1;
      end
   end

   assign instr    = instr_reg;
   assign pc_plus2 = pc_plus2_reg;
   assign valid    = valid_reg;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, the fetch/redirect/halt
// sequencer and the pending redirect target, and feeds IF/ID.
module fetch_stage
   import cpu_pkg::*;
#(
   parameter int              PC_W     = cpu_pkg::PC_W,
   parameter logic [PC_W-1:0] RESET_PC = '0,
   parameter logic [3:0]      HLT_OP   = cpu_pkg::HLT_OP
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req,
   output logic [PC_W-1:0] imem_addr,
   input  logic [PC_W-1:0] imem_rdata,
   input  logic            imem_ready,
   input  logic            stall_id,
   input  logic            br_taken,
   input  logic [PC_W-1:0] br_target,
   output logic [PC_W-1:0] id_instr,
   output logic [PC_W-1:0] id_pc_plus2,
   output logic            id_bubble,
   output logic            fetch_halted
);

   fetch_state_t    state_reg, state_next;
   logic [PC_W-1:0] pc_reg, pc_next;
   logic [PC_W-1:0] pend_target_reg, pend_target_next;
   logic            flush, hold;
   logic            id_valid;

   // Redirect targets are halfword aligned; bit 0 is dropped
   logic [PC_W-1:0] target;
   assign target = br_target & ~{{(PC_W-1){1'b0}}, 1'b1};

   // Sequential PC, wraps modulo 2^PC_W
   logic [PC_W-1:0] pc_plus2;
   assign pc_plus2 = pc_reg + PC_W'(2);

   // Next-state, PC and IF/ID control; priority br_taken > stall_id > imem_ready
   always_comb begin
      state_next       = state_reg;
      pc_next          = pc_reg;
      pend_target_next = pend_target_reg;
      flush            = 1'b0;
      hold             = 1'b0;
      unique case (state_reg)
         ST_FETCH: begin
            if (br_taken) begin
               flush = 1'b1;
               if (imem_ready) begin
                  pc_next = target;
               end else begin
                  // Outstanding access must finish before we can move
                  pend_target_next = target;
                  state_next       = ST_REDIR_PEND;
               end
            end else if (stall_id) begin
               // Data (if any) is dropped and re-fetched next cycle
               hold = 1'b1;
            end else if (!imem_ready) begin
               flush = 1'b1;
            end else if (imem_rdata[PC_W-1:PC_W-4] == HLT_OP) begin
               // HLT enters IF/ID; PC stays on it
               state_next = ST_HALTED;
            end else begin
               pc_next = pc_plus2;
            end
         end
         ST_REDIR_PEND: begin
            flush = 1'b1;
            if (br_taken) begin
               pend_target_next = target;
            end
            if (imem_ready) begin
               pc_next    = br_taken ? target : pend_target_reg;
               state_next = ST_FETCH;
            end
         end
         ST_HALTED: begin
            if (br_taken) begin
               // HLT was on a wrong path
               flush      = 1'b1;
               pc_next    = target;
               state_next = ST_FETCH;
            end else if (stall_id) begin
               hold = 1'b1;
            end else begin
               flush = 1'b1;
            end
         end
         default: begin
            flush      = 1'b1;
            state_next = ST_FETCH;
         end
      endcase
   end

   // Fetch state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg       <= ST_FETCH;
         pc_reg          <= RESET_PC;
         pend_target_reg <= '0;
      end else begin
         state_reg       <= state_next;
         pc_reg          <= pc_next;
         pend_target_reg <= pend_target_next;
      end
   end

   if_id_reg #(.W(PC_W)) u_if_id (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .hold       (hold),
      .instr_in   (imem_rdata),
      .pc_plus2_in(pc_plus2),
      .instr      (id_instr),
      .pc_plus2   (id_pc_plus2),
      .valid      (id_valid)
   );

   // All outputs derive from registered state only
   assign imem_req     = (state_reg != ST_HALTED);
   assign imem_addr    = pc_reg;
   assign fetch_halted = (state_reg == ST_HALTED);
   assign id_bubble    = ~id_valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed test of fetch_stage against a combinational instruction memory.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic [15:0] imem_rdata;
   logic        imem_ready;
   logic        stall_id;
   logic        br_taken;
   logic [15:0] br_target;
   logic [15:0] id_instr;
   logic [15:0] id_pc_plus2;
   logic        id_bubble;
   logic        fetch_halted;
   logic        hlt_en;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   // Memory: ADD-class word 0x1nnn with the low address bits, HLT at 0x0010 when enabled
   always_comb begin
      if (hlt_en && imem_addr == 16'h0010) imem_rdata = 16'hF000;
      else                                 imem_rdata = {4'h1, imem_addr[11:0]};
   end

   fetch_stage dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_rdata  (imem_rdata),
      .imem_ready  (imem_ready),
      .stall_id    (stall_id),
      .br_taken    (br_taken),
      .br_target   (br_target),
      .id_instr    (id_instr),
      .id_pc_plus2 (id_pc_plus2),
      .id_bubble   (id_bubble),
      .fetch_halted(fetch_halted)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One line per observed cycle
   task automatic show(input string what);
      $display("t=%0t %s addr=%h req=%b instr=%h pc2=%h bub=%b halt=%b",
               $time, what, imem_addr, imem_req, id_instr, id_pc_plus2, id_bubble, fetch_halted);
   endtask

   initial begin
      rst_n = 1'b0; imem_ready = 1'b1; stall_id = 1'b0; br_taken = 1'b0;
      br_target = 16'h0000; hlt_en = 1'b0;
      #12;
      show("reset");
      chk("rst_req", {15'd0, imem_req}, 16'd1);
      chk("rst_addr", imem_addr, 16'h0000);
      chk("rst_bub", {15'd0, id_bubble}, 16'd1);
      chk("rst_instr", id_instr, 16'h0000);
      chk("rst_pc2", id_pc_plus2, 16'h0000);
      chk("rst_halt", {15'd0, fetch_halted}, 16'd0);
      rst_n = 1'b1;

      // Hit path
      tick(); show("hit0");
      chk("hit0_pc2", id_pc_plus2, 16'h0002);
      chk("hit0_bub", {15'd0, id_bubble}, 16'd0);
      chk("hit0_instr", id_instr, 16'h1000);
      tick(); show("hit1");
      chk("hit1_pc2", id_pc_plus2, 16'h0004);
      chk("hit1_addr", imem_addr, 16'h0004);

      // 3-cycle miss at 0x0004
      imem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick(); show("miss");
         chk("miss_bub", {15'd0, id_bubble}, 16'd1);
         chk("miss_addr", imem_addr, 16'h0004);
      end
      imem_ready = 1'b1;
      tick(); show("miss_done");
      chk("missd_pc2", id_pc_plus2, 16'h0006);
      chk("missd_instr", id_instr, 16'h1004);
      tick(); show("hit2");
      chk("hit2_pc2", id_pc_plus2, 16'h0008);
      chk("hit2_addr", imem_addr, 16'h0008);

      // Stall 2 cycles at pc 0x0008
      stall_id = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick(); show("stall");
         chk("stall_pc2", id_pc_plus2, 16'h0008);
         chk("stall_instr", id_instr, 16'h1006);
         chk("stall_addr", imem_addr, 16'h0008);
      end
      stall_id = 1'b0;
      tick(); show("resume");
      chk("resume_instr", id_instr, 16'h1008);
      chk("resume_pc2", id_pc_plus2, 16'h000A);

      // Branch during hit, odd target
      br_taken = 1'b1; br_target = 16'h0041;
      tick(); show("br_hit");
      chk("brh_bub", {15'd0, id_bubble}, 16'd1);
      chk("brh_addr", imem_addr, 16'h0040);
      br_taken = 1'b0;
      tick(); show("br_hit_tgt");
      chk("brh_instr", id_instr, 16'h1040);
      chk("brh_pc2", id_pc_plus2, 16'h0042);

      // Branch during miss -> REDIR_PEND
      imem_ready = 1'b0; br_taken = 1'b1; br_target = 16'h0041;
      tick(); show("br_miss");
      chk("brm_bub", {15'd0, id_bubble}, 16'd1);
      chk("brm_addr", imem_addr, 16'h0042);
      br_taken = 1'b0;
      tick(); show("redir_wait");
      chk("brw_addr", imem_addr, 16'h0042);
      chk("brw_bub", {15'd0, id_bubble}, 16'd1);
      imem_ready = 1'b1;
      tick(); show("redir_done");
      chk("brd_bub", {15'd0, id_bubble}, 16'd1);
      chk("brd_addr", imem_addr, 16'h0040);
      tick(); show("redir_tgt");
      chk("brt_instr", id_instr, 16'h1040);

      // Halt at 0x0010
      hlt_en = 1'b1; br_taken = 1'b1; br_target = 16'h0010;
      tick(); show("br_to_hlt");
      chk("bh_addr", imem_addr, 16'h0010);
      br_taken = 1'b0;
      tick(); show("hlt");
      chk("hlt_instr", id_instr, 16'hF000);
      chk("hlt_pc2", id_pc_plus2, 16'h0012);
      chk("hlt_halted", {15'd0, fetch_halted}, 16'd1);
      chk("hlt_req", {15'd0, imem_req}, 16'd0);
      chk("hlt_addr", imem_addr, 16'h0010);
      tick(); show("halted");
      chk("hltd_halted", {15'd0, fetch_halted}, 16'd1);
      chk("hltd_bub", {15'd0, id_bubble}, 16'd1);
      chk("hltd_addr", imem_addr, 16'h0010);
      br_taken = 1'b1; br_target = 16'h0020;
      tick(); show("unhalt");
      chk("unh_halted", {15'd0, fetch_halted}, 16'd0);
      chk("unh_req", {15'd0, imem_req}, 16'd1);
      chk("unh_addr", imem_addr, 16'h0020);
      br_taken = 1'b0;
      tick(); show("unhalt_tgt");
      chk("unh_pc2", id_pc_plus2, 16'h0022);

      // PC wrap
      br_taken = 1'b1; br_target = 16'hFFFE;
      tick(); show("br_wrap");
      chk("wrap_addr0", imem_addr, 16'hFFFE);
      br_taken = 1'b0;
      tick(); show("wrap");
      chk("wrap_addr", imem_addr, 16'h0000);
      chk("wrap_pc2", id_pc_plus2, 16'h0000);
      chk("wrap_instr", id_instr, 16'h1FFE);
      chk("wrap_bub", {15'd0, id_bubble}, 16'd0);

      // Async reset in REDIR_PEND
      br_taken = 1'b1; br_target = 16'h0030;
      tick();
      br_taken = 1'b0;
      tick(); show("pre_redir");
      chk("pr_addr", imem_addr, 16'h0032);
      imem_ready = 1'b0; br_taken = 1'b1; br_target = 16'h0050;
      tick(); show("redir_pend");
      br_taken = 1'b0;
      #2 rst_n = 1'b0;
      #1; show("async_rst");
      chk("ar_addr", imem_addr, 16'h0000);
      chk("ar_bub", {15'd0, id_bubble}, 16'd1);
      chk("ar_instr", id_instr, 16'h0000);
      chk("ar_req", {15'd0, imem_req}, 16'd1);
      chk("ar_halt", {15'd0, fetch_halted}, 16'd0);
      rst_n = 1'b1; imem_ready = 1'b1;
      tick(); show("post_rst");
      chk("prst_pc2", id_pc_plus2, 16'h0002);
      chk("prst_bub", {15'd0, id_bubble}, 16'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register of the 16-bit pipelined CPU. Holds the PC, drives the instruction-memory/I-cache request, absorbs cache-miss wait cycles, applies EX-stage branch redirects and ID-stage hazard stalls, and freezes fetch on HLT. Feeds the decode stage: `id_instr[15:12]` is the opcode into the control decoder, and `id_bubble` drives its instruction-stall kill input.

## Interface
- `PC_W`, 16, PC and instruction width
- `RESET_PC`, 16'h0000, PC value after reset
- `HLT_OP`, 4'hF, opcode that freezes fetch

- `clk` in 1 — single clock; all state updates on rising edge
- `rst_n` in 1 — asynchronous, active-low reset
- `imem_req` out 1 — fetch request valid
- `imem_addr` out PC_W — fetch address; held stable while `imem_ready`=0
- `imem_rdata` in PC_W — instruction; valid when `imem_ready`=1
- `imem_ready` in 1 — same-cycle hit/complete for `imem_addr`
- `stall_id` in 1 — load-use hazard from ID; hold PC and IF/ID
- `br_taken` in 1 — EX branch resolved taken; redirect and flush
- `br_target` in PC_W — redirect address; bit 0 forced to 0
- `id_instr` out PC_W — IF/ID instruction
- `id_pc_plus2` out PC_W — IF/ID PC+2 (link value for PCS)
- `id_bubble` out 1 — 1 when IF/ID holds no valid instruction
- `fetch_halted` out 1 — 1 in HALTED state

## Operation
- FSM states: FETCH, REDIR_PEND, HALTED. Registers: `pc`, `pend_target`, IF/ID {instr, pc_plus2, valid}.
- Accept = FETCH & `imem_ready` & ~`stall_id` & ~`br_taken`.
- FETCH: `imem_req`=1, `imem_addr`=`pc`.
  - `br_taken` & `imem_ready`: `pc`<=target; IF/ID<=bubble.
  - `br_taken` & ~`imem_ready`: `pend_target`<=target; ->REDIR_PEND; IF/ID<=bubble; `pc` held.
  - else `stall_id`: `pc` and IF/ID held (even if `imem_ready`=1; data re-fetched next cycle).
  - else ~`imem_ready`: `pc` held; IF/ID<=bubble.
  - else accept: IF/ID<={`imem_rdata`, `pc`+2, valid}; if `imem_rdata[15:12]`==HLT_OP, `pc` held and ->HALTED; else `pc`<=`pc`+2.
- REDIR_PEND: `imem_req`=1, `imem_addr`=`pc` (old access completes, never aborted). IF/ID<=bubble every cycle. New `br_taken` overwrites `pend_target`. On `imem_ready`: data discarded, `pc`<=`pend_target` (or `br_target` if `br_taken` same cycle), ->FETCH.
- HALTED: `imem_req`=0; IF/ID<=bubble unless `stall_id` (hold). `br_taken` (wrong-path HLT): `pc`<=target, ->FETCH, IF/ID<=bubble.
- Bubble: valid=0, instr=16'h0000, pc_plus2=0.
- Arithmetic: `pc`+2 modulo 2^PC_W (16'hFFFE -> 16'h0000). `br_target[0]` ignored.
- Priority: `rst_n` > `br_taken` > `stall_id` > `imem_ready`.

## Timing
- Reset (async, any state): `pc`=RESET_PC, state=FETCH, `pend_target`=0, IF/ID=bubble. Outputs during/after reset: `imem_req`=1, `imem_addr`=RESET_PC, `id_bubble`=1, `id_instr`=0, `id_pc_plus2`=0, `fetch_halted`=0.
- Hit path: instruction at `imem_addr` in cycle N appears on `id_instr` in N+1; throughput 1/cycle.
- Redirect with hit: first target instruction on `id_instr` 2 cycles after `br_taken` (one bubble).
- Miss of k cycles: k bubbles in IF/ID, then instruction.
- `imem_addr`, `imem_req`, `fetch_halted`, `id_*` are purely registered-state functions; no combinational path from inputs to outputs.

## Structure
- Shared package `cpu_pkg`: opcode constants (HLT_OP, branch opcodes), `fetch_state_t` enum, PC_W, bubble encoding.
- Sub-module `if_id_reg`: IF/ID register with hold (stall) and flush (bubble) controls; fetch_stage owns PC, FSM, `pend_target`.

## Test plan
- Reset, `imem_ready`=1, memory 0x0000..0x0006 = ADD words -> `id_pc_plus2` 2,4,6,8 on successive cycles, `id_bubble`=0 from cycle 2.
- `imem_ready`=0 for 3 cycles at pc=0x0004 -> 3 bubbles, `imem_addr` stable 0x0004, then instruction with `id_pc_plus2`=0x0006.
- `stall_id`=1 for 2 cycles at pc=0x0008 -> `id_instr` and `pc` unchanged, then resumes at 0x0008.
- `br_taken`, target=0x0041 during hit -> one bubble, next `imem_addr`=0x0040; during miss -> REDIR_PEND, old fetch discarded on ready, then `imem_addr`=0x0040.
- Fetch 16'hF000 at 0x0010 -> `fetch_halted`=1, `imem_req`=0, `pc`=0x0010; then `br_taken` target 0x0020 -> FETCH at 0x0020.
- PC 0xFFFE accepted -> next `imem_addr`=0x0000; `rst_n` low mid-REDIR_PEND -> immediate reset values.
